shift_arb_ctrl: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8-bit barrel_shifter datapath between NUM_REQ requesters.
- Each requester offers a shift operation over a valid/ready handshake. The operation is a data byte, a direction and a 3-bit amount.
- The block grants one request at a time, registers the operands, captures the shifter result and presents it with the requester ID on a single valid/ready output port.
- Sits between the requesting engines and the shared shifter instance, which it instantiates internally.

---
 rtl/shift_arb_ctrl_if.sv | 33 +++
 rtl/shift_arb_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_shift_arb_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arb_ctrl_if.sv
// ============================================================================
// shift_arb_ctrl_if : requester/result bundle for the shared-shifter arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface shift_arb_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_dir;
  logic [NUM_REQ*3-1:0] req_amt;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_data;
  logic [ID_W-1:0]      out_id;
  logic                 busy;

  modport master (
    output req_valid, req_data, req_dir, req_amt, out_ready,
    input  req_ready, out_valid, out_data, out_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_dir, req_amt, out_ready,
    output req_ready, out_valid, out_data, out_id, busy
  );
endinterface

`default_nettype wire

// File: rtl/shift_arb_ctrl.sv
// ============================================================================
// shift_arb_ctrl : round-robin arbiter sharing one 8-bit barrel shifter.
// Optional per-requester grant counters under SHIFT_ARB_STATS_EN. Rev 1.0
// ============================================================================
`default_nettype none

module barrel_shifter (
  input  logic [7:0] data_in,
  input  logic       dir,
  input  logic [2:0] amt,
  output logic [7:0] data_out
);
  logic [7:0] v;

  // Logarithmic stages of 1, 2 and 4 bit positions, zero fill.
  always_comb begin
    v = data_in;
    for (int s = 0; s < 3; s++) begin
      if (amt[s]) begin
        v = dir ? (v << (1 << s)) : (v >> (1 << s));
      end
    end
    data_out = v;
  end
endmodule

module shift_arb_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_arb_ctrl_if.slave bus
`ifdef SHIFT_ARB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       op_id_q, op_id_d;
  logic [DATA_WIDTH-1:0] op_data_q, op_data_d;
  logic                  op_dir_q, op_dir_d;
  logic [2:0]            op_amt_q, op_amt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;

  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       cand;
  logic                  grant_vld;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] shift_res;

  // Walk from the farthest candidate toward rr_ptr+1 so the nearest valid wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((32'(rr_ptr_q) + 32'(k)) % 32'(NUM_REQ));
      if (bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Gated by rst_n so ready is low for the whole reset interval.
  assign req_ready = (rst_n && (state_q == IDLE) && grant_vld)
                   ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx)
                   : '0;
  assign accept    = |req_ready;

  barrel_shifter u_shifter (
    .data_in  (op_data_q),
    .dir      (op_dir_q),
    .amt      (op_amt_q),
    .data_out (shift_res)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_id_d     = op_id_q;
    op_data_d   = op_data_q;
    op_dir_d    = op_dir_q;
    op_amt_d    = op_amt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_data_d = bus.req_data[DATA_WIDTH*grant_idx +: DATA_WIDTH];
          op_dir_d  = bus.req_dir[grant_idx];
          op_amt_d  = bus.req_amt[3*grant_idx +: 3];
          op_id_d   = grant_idx;
          rr_ptr_d  = grant_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        out_data_d  = shift_res;
        out_id_d    = op_id_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      op_id_q     <= '0;
      op_data_q   <= '0;
      op_dir_q    <= 1'b0;
      op_amt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_id_q     <= op_id_d;
      op_data_q   <= op_data_d;
      op_dir_q    <= op_dir_d;
      op_amt_q    <= op_amt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.busy      = (state_q != IDLE);

`ifdef SHIFT_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle grant; counters stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (stats_clr) begin
      cnt_d = '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (cnt_q[i] != 16'hFFFF)) begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_arb_ctrl.sv
// ============================================================================
// tb_shift_arb_ctrl : directed bench with a per-cycle reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_shift_arb_ctrl;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_arb_ctrl_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

`ifdef SHIFT_ARB_STATS_EN
  logic                  stats_clr;
  logic [NUM_REQ*16-1:0] grant_cnt;
`endif

  shift_arb_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic: multiply/divide by 2**amt.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic dir, input logic [2:0] a);
    int v;
    int p;
    v = int'(d);
    p = 1 << a;
    return dir ? 8'((v * p) % 256) : 8'(v / p);
  endfunction

  // Model: m_phase counts edges since accept (0 = nothing outstanding).
  int               m_phase = 0;
  int               m_last  = NUM_REQ - 1;
  logic [7:0]       m_data;
  int               m_id;
  int               g;
  logic [NUM_REQ-1:0] exp_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
      m_last  = NUM_REQ - 1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'd0);
      chk("rst_out_id",    32'(bus.out_id),    32'd0);
    end else begin
      g       = -1;
      exp_rdy = '0;
      if (m_phase == 0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (g < 0 && bus.req_valid[(m_last + k) % NUM_REQ]) g = (m_last + k) % NUM_REQ;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("busy",      32'(bus.busy),      32'(m_phase != 0));
      chk("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        chk("out_data", 32'(bus.out_data), 32'(m_data));
        chk("out_id",   32'(bus.out_id),   32'(m_id));
      end
      case (m_phase)
        0: if (g >= 0) begin
             m_phase = 1;
             m_last  = g;
             m_id    = g;
             m_data  = ref_shift(bus.req_data[8*g +: 8], bus.req_dir[g], bus.req_amt[3*g +: 3]);
           end
        1: m_phase = 2;
        default: if (bus.out_ready) m_phase = 0;
      endcase
    end
  end

  // Wait (bounded) for a grant; returns its index and ready vector.
  task automatic wait_accept(input bit drop, output int idx, output logic [NUM_REQ-1:0] rdy);
    int t;
    t   = 0;
    idx = -1;
    rdy = '0;
    while (idx < 0 && t < 50) begin
      @(negedge clk);
      t++;
      if (bus.req_ready != '0) begin
        rdy = bus.req_ready;
        for (int k = 0; k < NUM_REQ; k++) if (rdy[k]) idx = k;
      end
    end
    if (idx < 0) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    if (drop && idx >= 0) bus.req_valid[idx] = 1'b0;
  endtask

  task automatic do_op(input int r, input logic [7:0] d, input logic dir,
                       input logic [2:0] a, input logic [7:0] exp_d);
    int n;
    logic [NUM_REQ-1:0] rdy;
    @(posedge clk);
    #1;
    bus.req_data[8*r +: 8] = d;
    bus.req_dir[r]         = dir;
    bus.req_amt[3*r +: 3]  = a;
    bus.req_valid[r]       = 1'b1;
    wait_accept(1'b1, n, rdy);
    chk("op_grant", 32'(n), 32'(r));
    chk("op_ready_vec", 32'(rdy), 32'(1 << r));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 10);
    chk("op_latency", 32'(n), 32'd2);
    chk("op_data", 32'(bus.out_data), 32'(exp_d));
    chk("op_id", 32'(bus.out_id), 32'(r));
  endtask

  int order [5];
  int idx;
  logic [NUM_REQ-1:0] rv;
  logic [7:0] hold_d;
  logic [ID_W-1:0] hold_i;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_dir   = '0;
    bus.req_amt   = '0;
    bus.out_ready = 1'b1;
`ifdef SHIFT_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op(0, 8'hB5, 1'b1, 3'd3, 8'hA8);
    do_op(2, 8'hB5, 1'b0, 3'd3, 8'h16);
    do_op(2, 8'hB5, 1'b0, 3'd0, 8'hB5);
    do_op(2, 8'h01, 1'b1, 3'd7, 8'h80);

    // Fresh reset so the round-robin pointer starts at requester 0.
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.req_data[8*r +: 8] = 8'((r + 1) * 17);
      bus.req_dir[r]         = r[0];
      bus.req_amt[3*r +: 3]  = 3'(r + 1);
    end
    bus.req_valid = '1;
    for (int n = 0; n < 5; n++) wait_accept(1'b0, order[n], rv);
    bus.req_valid = '0;
    chk("rr_order0", 32'(order[0]), 32'd0);
    chk("rr_order1", 32'(order[1]), 32'd1);
    chk("rr_order2", 32'(order[2]), 32'd2);
    chk("rr_order3", 32'(order[3]), 32'd3);
    chk("rr_order4", 32'(order[4]), 32'd0);
    repeat (4) @(posedge clk);

    // Downstream stall with a competing request waiting.
    #1;
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1010;
    wait_accept(1'b1, idx, rv);
    chk("stall_grant", 32'(idx), 32'd1);
    while (!bus.out_valid) @(negedge clk);
    hold_d = bus.out_data;
    hold_i = bus.out_id;
    chk("stall_id", 32'(hold_i), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data",  32'(bus.out_data),  32'(hold_d));
      chk("stall_id_hold", 32'(bus.out_id),  32'(hold_i));
      chk("stall_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_accept(1'b1, idx, rv);
    chk("after_stall_grant", 32'(idx), 32'd3);
    repeat (4) @(posedge clk);

    // Asynchronous reset while an operation is in EXEC.
    #1 bus.req_valid = 4'b0100;
    wait_accept(1'b0, idx, rv);
    chk("exec_grant", 32'(idx), 32'd2);
    bus.req_valid[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",      32'(bus.busy),      32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_accept(1'b1, idx, rv);
    chk("post_rst_grant", 32'(idx), 32'd0);
    chk("post_rst_ready", 32'(rv), 32'd1);
    wait_accept(1'b1, idx, rv);
    chk("post_rst_grant2", 32'(idx), 32'd2);
    repeat (4) @(posedge clk);

`ifdef SHIFT_ARB_STATS_EN
    #1 stats_clr = 1'b1;
    @(posedge clk);
    #1 stats_clr = 1'b0;
    for (int n = 0; n < 3; n++) do_op(1, 8'h0F, 1'b1, 3'd1, 8'h1E);
    @(negedge clk);
    chk("cnt_req1", 32'(grant_cnt[31:16]), 32'd3);
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b1;
    stats_clr = 1'b1;
    wait_accept(1'b1, idx, rv);
    stats_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_wins", 32'(grant_cnt[31:16]), 32'd0);
    repeat (4) @(posedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
